// File: rtl/adc_clkgen_mc.sv
// adc_clkgen_mc: lock-qualified multi-channel ADC clock/strobe generator.
// Each channel divides refclk by a programmable ratio and emits a square
// div_clk plus a one-cycle sample strobe at a programmable phase.
// Optional feature macro: ADC_CLKGEN_SYNC_EN adds sync_in, whose rising
// edge realigns all running channels to count 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// UNLOCKED  | PLL not locked, outputs held low
// QUALIFY   | PLL locked, counting down the qualification window
// RUN       | qualified; channels divide and strobe, ready high
module adc_clkgen_mc #(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 16,
    parameter int LOCK_CNT = 1024
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [NUM_CH*DIV_W-1:0] phase,
    input  logic                    cfg_load,
`ifdef ADC_CLKGEN_SYNC_EN
    input  logic                    sync_in,
`endif
    output logic [NUM_CH-1:0]       div_clk,
    output logic [NUM_CH-1:0]       strobe,
    output logic                    ready
);

    localparam logic [1:0] S_UNLOCKED = 2'd0;
    localparam logic [1:0] S_QUALIFY  = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;

    localparam int QW = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;
    localparam logic [QW-1:0] Q_LOAD = QW'(LOCK_CNT - 2);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [QW-1:0] qcnt;
    logic          run_stay;
    logic          sync_rise;

    // Next-state decode of the lock FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_UNLOCKED: if (pll_locked) state_nxt = S_QUALIFY;
            S_QUALIFY: begin
                if (!pll_locked)       state_nxt = S_UNLOCKED;
                else if (qcnt == '0)   state_nxt = S_RUN;
            end
            S_RUN:      if (!pll_locked) state_nxt = S_UNLOCKED;
            default:    state_nxt = S_UNLOCKED;
        endcase
    end

    // State, qualify down-counter and registered ready flag.
    // The first locked sample is taken in UNLOCKED, so the counter is
    // loaded with LOCK_CNT-2 and RUN is entered on the LOCK_CNT-th sample.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state <= S_UNLOCKED;
            qcnt  <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == S_RUN);
            if (state == S_UNLOCKED && pll_locked)
                qcnt <= Q_LOAD;
            else if (state == S_QUALIFY && pll_locked && qcnt != '0)
                qcnt <= qcnt - 1'b1;
            else
                qcnt <= '0;
        end
    end

    // Channels only advance while RUN persists across this edge; a lock
    // dropout zeroes everything on the same edge that ready falls.
    assign run_stay = (state == S_RUN) && pll_locked;

`ifdef ADC_CLKGEN_SYNC_EN
    logic sync_q;

    // Previous sync_in level for rising-edge detection.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) sync_q <= 1'b0;
        else      sync_q <= sync_in;
    end

    assign sync_rise = run_stay && sync_in && !sync_q;
`else
    assign sync_rise = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] d_act;
        logic [DIV_W-1:0] p_act;
        logic [DIV_W-1:0] d_sh;
        logic [DIV_W-1:0] p_sh;
        logic             pend;
        logic             div_q;
        logic             stb_q;

        logic [DIV_W-1:0] d_in;
        logic [DIV_W-1:0] p_in;
        logic [DIV_W-1:0] d_eff;
        logic [DIV_W-1:0] d_last;
        logic [DIV_W-1:0] p_eff;
        logic [DIV_W-1:0] half;
        logic             ch_run;
        logic             restart;
        logic             apply;

        assign d_in    = div_ratio[i*DIV_W +: DIV_W];
        assign p_in    = phase[i*DIV_W +: DIV_W];
        assign d_eff   = (d_act == '0) ? DIV_W'(1) : d_act;
        assign d_last  = d_eff - DIV_W'(1);
        assign p_eff   = (p_act > d_last) ? d_last : p_act;
        assign half    = (d_eff >> 1) + DIV_W'(d_eff[0]);
        assign ch_run  = run_stay && ch_en[i];
        assign restart = ch_run && ((cnt == d_last) || sync_rise);
        // New settings land only where a period begins, so no period ever
        // mixes two ratios; a load on the wrap edge itself goes straight in.
        assign apply   = (!ch_run || restart) && (cfg_load || pend);

        // Period counter and registered channel outputs.
        always_ff @(posedge refclk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                div_q <= 1'b0;
                stb_q <= 1'b0;
            end else begin
                cnt   <= (ch_run && !restart) ? cnt + 1'b1 : '0;
                div_q <= ch_run && (cnt < half);
                stb_q <= ch_run && (cnt == p_eff);
            end
        end

        // Shadow capture and shadow-to-active transfer.
        always_ff @(posedge refclk or negedge rst) begin
            if (!rst) begin
                d_act <= DIV_W'(1);
                p_act <= '0;
                d_sh  <= DIV_W'(1);
                p_sh  <= '0;
                pend  <= 1'b0;
            end else begin
                if (apply) begin
                    d_act <= cfg_load ? d_in : d_sh;
                    p_act <= cfg_load ? p_in : p_sh;
                end
                if (cfg_load) begin
                    d_sh <= d_in;
                    p_sh <= p_in;
                end
                if (apply)         pend <= 1'b0;
                else if (cfg_load) pend <= 1'b1;
            end
        end

        assign div_clk[i] = div_q;
        assign strobe[i]  = stb_q;
    end

endmodule

// File: tb/tb_adc_clkgen_mc.sv
// Self-checking bench for adc_clkgen_mc (two channels, short lock window).
module tb_adc_clkgen_mc;

    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 8;
    localparam int LOCK_CNT = 16;

    logic                    refclk = 1'b0;
    logic                    rst;
    logic                    pll_locked;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic [NUM_CH*DIV_W-1:0] phase;
    logic                    cfg_load;
    logic                    sync_in;
    logic [NUM_CH-1:0]       div_clk;
    logic [NUM_CH-1:0]       strobe;
    logic                    ready;

    adc_clkgen_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CNT(LOCK_CNT)) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .ch_en      (ch_en),
        .div_ratio  (div_ratio),
        .phase      (phase),
        .cfg_load   (cfg_load),
`ifdef ADC_CLKGEN_SYNC_EN
        .sync_in    (sync_in),
`endif
        .div_clk    (div_clk),
        .strobe     (strobe),
        .ready      (ready)
    );

    always #5 refclk = ~refclk;

    int errors = 0;
    int checks = 0;

    // Reference model: ready = "at least LOCK_CNT consecutive locked
    // samples"; each channel tracks the age of its current period.
    int          m_len;
    bit          m_ready;
    bit          m_sync_prev;
    int          m_age [NUM_CH];
    int          m_d   [NUM_CH];
    int          m_p   [NUM_CH];
    int          m_sd  [NUM_CH];
    int          m_sp  [NUM_CH];
    bit          m_pend[NUM_CH];
    logic [NUM_CH-1:0] e_div;
    logic [NUM_CH-1:0] e_stb;

    typedef struct {
        int d;
        int p;
        int first;
        int nstb;
        int ndiv;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_len = 0;
        m_ready = 1'b0;
        m_sync_prev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_age[i] = 0; m_d[i] = 1; m_p[i] = 0;
            m_sd[i] = 1; m_sp[i] = 0; m_pend[i] = 1'b0;
        end
        e_div = '0;
        e_stb = '0;
    endfunction

    function automatic void model_step();
        bit stays, sev, act, eop;
        int d, p;
        stays = m_ready && pll_locked;
        sev   = stays && sync_in && !m_sync_prev;
        for (int i = 0; i < NUM_CH; i++) begin
            d = (m_d[i] == 0) ? 1 : m_d[i];
            p = (m_p[i] > d - 1) ? d - 1 : m_p[i];
            act = stays && ch_en[i];
            e_stb[i] = act && (m_age[i] == p);
            e_div[i] = act && (m_age[i] < (d + 1) / 2);
            eop = act && ((m_age[i] == d - 1) || sev);
            m_age[i] = (act && !eop) ? m_age[i] + 1 : 0;
            if ((!act || eop) && (cfg_load || m_pend[i])) begin
                m_d[i] = cfg_load ? int'(div_ratio[i*DIV_W +: DIV_W]) : m_sd[i];
                m_p[i] = cfg_load ? int'(phase[i*DIV_W +: DIV_W])     : m_sp[i];
                m_pend[i] = 1'b0;
            end else if (cfg_load) begin
                m_pend[i] = 1'b1;
            end
            if (cfg_load) begin
                m_sd[i] = int'(div_ratio[i*DIV_W +: DIV_W]);
                m_sp[i] = int'(phase[i*DIV_W +: DIV_W]);
            end
        end
        if (pll_locked) m_len = (m_len < LOCK_CNT) ? m_len + 1 : LOCK_CNT;
        else            m_len = 0;
        m_ready = (m_len >= LOCK_CNT);
        m_sync_prev = sync_in;
    endfunction

    // One refclk edge: inputs already driven; compare all outputs to model.
    task automatic cycle();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        chk("cyc", int'({ready, div_clk, strobe}), int'({m_ready, e_div, e_stb}));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pll_locked = 1'b0;
        cfg_load = 1'b0;
        sync_in = 1'b0;
        #1;
        chk("rst_out", int'({ready, div_clk, strobe}), 0);
        model_reset();
        @(negedge refclk);
        rst = 1'b1;
    endtask

    task automatic load_cfg(input int d0, input int p0, input int d1, input int p1);
        div_ratio = {DIV_W'(d1), DIV_W'(d0)};
        phase     = {DIV_W'(p1), DIV_W'(p0)};
        cfg_load  = 1'b1;
        cycle();
        cfg_load  = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        bit seen;
        seen = 1'b0;
        n = LOCK_CNT + 5;
        pll_locked = 1'b1;
        for (int k = 1; k <= LOCK_CNT + 4; k++) begin
            if (!seen) begin
                cycle();
                if (ready) begin
                    seen = 1'b1;
                    n = k;
                end
            end
        end
    endtask

    initial begin
        int n, first, nstb, ndiv;
        logic [13:0] dpat, spat;

        tbl[0] = '{d: 4, p: 1, first: 2, nstb: 6,  ndiv: 12};
        tbl[1] = '{d: 5, p: 7, first: 5, nstb: 4,  ndiv: 15};
        tbl[2] = '{d: 0, p: 0, first: 1, nstb: 24, ndiv: 24};
        tbl[3] = '{d: 1, p: 5, first: 1, nstb: 24, ndiv: 24};
        tbl[4] = '{d: 6, p: 0, first: 1, nstb: 4,  ndiv: 12};
        tbl[5] = '{d: 7, p: 3, first: 4, nstb: 3,  ndiv: 15};

        ch_en = '0;
        div_ratio = '0;
        phase = '0;
        do_reset();

        // Lock timing and steady-state waveform per divide/phase setting.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            ch_en = 2'b01;
            load_cfg(tbl[v].d, tbl[v].p, 3, 1);
            wait_ready(n);
            chk("lock_len", n, LOCK_CNT);
            first = 0; nstb = 0; ndiv = 0;
            for (int j = 1; j <= 24; j++) begin
                cycle();
                if (strobe[0] && first == 0) first = j;
                nstb += int'(strobe[0]);
                ndiv += int'(div_clk[0]);
            end
            chk("first_stb", first, tbl[v].first);
            chk("num_stb", nstb, tbl[v].nstb);
            chk("div_high", ndiv, tbl[v].ndiv);
        end

        // Reload mid-period: the running 8-cycle period completes first.
        do_reset();
        ch_en = 2'b01;
        load_cfg(8, 0, 1, 0);
        wait_ready(n);
        chk("lock_len", n, LOCK_CNT);
        dpat = '0; spat = '0;
        for (int k = 1; k <= 14; k++) begin
            cfg_load = (k == 3);
            if (k == 3) div_ratio[DIV_W-1:0] = DIV_W'(3);
            cycle();
            dpat[k-1] = div_clk[0];
            spat[k-1] = strobe[0];
        end
        cfg_load = 1'b0;
        chk("reload_div", int'(dpat), int'(14'b01101100001111));
        chk("reload_stb", int'(spat), int'(14'b00100100000001));

        // Single-cycle lock dropout in RUN.
        pll_locked = 1'b0;
        cycle();
        chk("drop_out", int'({ready, div_clk, strobe}), 0);
        wait_ready(n);
        chk("relock_len", n, LOCK_CNT);

        // Asynchronous reset in the middle of a cycle.
        for (int k = 0; k < 5; k++) cycle();
        #2;
        do_reset();
        ch_en = 2'b11;
        wait_ready(n);
        chk("post_rst_lock", n, LOCK_CNT);

`ifdef ADC_CLKGEN_SYNC_EN
        do_reset();
        ch_en = 2'b11;
        load_cfg(4, 0, 6, 0);
        wait_ready(n);
        for (int k = 0; k < 7; k++) cycle();
        sync_in = 1'b1;
        cycle();
        sync_in = 1'b0;
        cycle();
        chk("sync_align", int'(strobe), 3);
        for (int k = 0; k < 12; k++) cycle();
`endif

        // Randomised traffic against the reference model.
        do_reset();
        ch_en = 2'b11;
        pll_locked = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            pll_locked = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) < 3) ch_en = NUM_CH'($urandom_range(0, 3));
            cfg_load = ($urandom_range(0, 99) < 5);
            if (cfg_load) begin
                div_ratio = {DIV_W'($urandom_range(0, 9)), DIV_W'($urandom_range(0, 9))};
                phase     = {DIV_W'($urandom_range(0, 11)), DIV_W'($urandom_range(0, 11))};
            end
`ifdef ADC_CLKGEN_SYNC_EN
            sync_in = ($urandom_range(0, 99) < 4);
`endif
            cycle();
        end
        cfg_load = 1'b0;
        sync_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
